// File: rtl/mem_lsu_if.sv
// Memory bus between the load/store unit and the data memory.
// The LSU is the master: it raises bus_req with a stable beat until bus_ack.
interface mem_lsu_if #(
  parameter int XLEN = 64
);
  logic              bus_req;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN/8-1:0] bus_wmask;
  logic [XLEN-1:0]   bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Non-memory ops and misaligned accesses complete
// in the same cycle; aligned accesses stall upstream while one bus beat runs
// (IDLE -> BUS -> RESP -> IDLE). Bus beats are 8-byte aligned with lane masks.
module mem_lsu #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic              mem_en_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_uns_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_sdata_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic              misalign_o,
  mem_lsu_if.master         bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t              state_reg;
  logic [REG_AW-1:0]   wd_reg;
  logic                wreg_reg;
  logic                we_reg;
  logic                uns_reg;
  logic [1:0]          size_reg;
  logic [2:0]          lane_reg;
  logic [XLEN-1:0]     rdata_reg;
  logic                bus_req_reg;
  logic                bus_we_reg;
  logic [XLEN-1:0]     bus_addr_reg;
  logic [XLEN-1:0]     bus_wdata_reg;
  logic [7:0]          bus_wmask_reg;

  logic                misaligned;
  logic                accept;
  logic [7:0]          size_mask;
  logic [XLEN-1:0]     load_shifted;
  logic [XLEN-1:0]     load_data;

  // Natural alignment: address must be a multiple of the access size.
  always_comb begin
    misaligned = 1'b0;
    case (mem_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = mem_addr_i[0];
      2'd2:    misaligned = |mem_addr_i[1:0];
      default: misaligned = |mem_addr_i[2:0];
    endcase
  end

  assign accept = (state_reg == IDLE) && valid_i && mem_en_i && !misaligned;

  // Byte-lane mask for the access size before shifting into place.
  always_comb begin
    size_mask = 8'hFF;
    case (mem_size_i)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Pull the loaded lanes down to bit 0, then sign- or zero-extend.
  always_comb begin
    load_shifted = rdata_reg >> {lane_reg, 3'b000};
    load_data    = load_shifted;
    case (size_reg)
      2'd0:    load_data = {{(XLEN-8){load_shifted[7] & ~uns_reg}}, load_shifted[7:0]};
      2'd1:    load_data = {{(XLEN-16){load_shifted[15] & ~uns_reg}}, load_shifted[15:0]};
      2'd2:    load_data = {{(XLEN-32){load_shifted[31] & ~uns_reg}}, load_shifted[31:0]};
      default: load_data = load_shifted;
    endcase
  end

  // FSM with registered request fields and registered bus beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wd_reg        <= '0;
      wreg_reg      <= 1'b0;
      we_reg        <= 1'b0;
      uns_reg       <= 1'b0;
      size_reg      <= 2'd0;
      lane_reg      <= 3'd0;
      rdata_reg     <= '0;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_wmask_reg <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            wd_reg        <= wd_i;
            wreg_reg      <= wreg_i;
            we_reg        <= mem_we_i;
            uns_reg       <= mem_uns_i;
            size_reg      <= mem_size_i;
            lane_reg      <= mem_addr_i[2:0];
            bus_req_reg   <= 1'b1;
            bus_we_reg    <= mem_we_i;
            bus_addr_reg  <= {mem_addr_i[XLEN-1:3], 3'b000};
            bus_wdata_reg <= mem_sdata_i << {mem_addr_i[2:0], 3'b000};
            bus_wmask_reg <= size_mask << mem_addr_i[2:0];
            state_reg     <= BUS;
          end
        end
        BUS: begin
          if (bus.bus_ack) begin
            rdata_reg   <= bus.bus_rdata;
            bus_req_reg <= 1'b0;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Result/stall outputs; reset forces everything low, including pass-through.
  always_comb begin
    stall_o    = 1'b0;
    valid_o    = 1'b0;
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    misalign_o = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            if (!mem_en_i) begin
              valid_o = 1'b1;
              wd_o    = wd_i;
              wreg_o  = wreg_i;
              wdata_o = wdata_i;
            end else if (misaligned) begin
              valid_o    = 1'b1;
              wd_o       = wd_i;
              misalign_o = 1'b1;
            end else begin
              stall_o = 1'b1;
            end
          end
        end
        BUS: begin
          stall_o = 1'b1;
        end
        RESP: begin
          valid_o = 1'b1;
          wd_o    = wd_reg;
          wreg_o  = wreg_reg & ~we_reg;
          wdata_o = we_reg ? '0 : load_data;
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_req   = bus_req_reg & ~rst;
  assign bus.bus_we    = bus_we_reg & ~rst;
  assign bus.bus_addr  = rst ? '0 : bus_addr_reg;
  assign bus.bus_wdata = rst ? '0 : bus_wdata_reg;
  assign bus.bus_wmask = rst ? '0 : bus_wmask_reg;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: single-cycle cases from a vector table, multi-cycle bus
// sequences by hand, results checked against a queue of expected writebacks.
module tb_mem_lsu;
  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic [REG_AW-1:0] wd_i;
  logic              wreg_i;
  logic [XLEN-1:0]   wdata_i;
  logic              mem_en_i;
  logic              mem_we_i;
  logic [1:0]        mem_size_i;
  logic              mem_uns_i;
  logic [XLEN-1:0]   mem_addr_i;
  logic [XLEN-1:0]   mem_sdata_i;
  logic              stall_o;
  logic              valid_o;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;
  logic [XLEN-1:0]   wdata_o;
  logic              misalign_o;

  mem_lsu_if #(.XLEN(XLEN)) bus ();

  mem_lsu #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_en_i    (mem_en_i),
    .mem_we_i    (mem_we_i),
    .mem_size_i  (mem_size_i),
    .mem_uns_i   (mem_uns_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .stall_o     (stall_o),
    .valid_o     (valid_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .misalign_o  (misalign_o),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic [XLEN-1:0]   wdata;
    logic              chk_wdata;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic              v;
    logic              en;
    logic              we;
    logic [1:0]        size;
    logic [XLEN-1:0]   addr;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic [XLEN-1:0]   wdata;
    logic              e_valid;
    logic              e_wreg;
    logic              e_mis;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic en, input logic we, input logic [1:0] size,
                       input logic uns, input logic [XLEN-1:0] addr, input logic [XLEN-1:0] sdata,
                       input logic [REG_AW-1:0] wd, input logic wreg, input logic [XLEN-1:0] wdata);
    valid_i     = v;
    mem_en_i    = en;
    mem_we_i    = we;
    mem_size_i  = size;
    mem_uns_i   = uns;
    mem_addr_i  = addr;
    mem_sdata_i = sdata;
    wd_i        = wd;
    wreg_i      = wreg;
    wdata_i     = wdata;
  endtask

  task automatic push_exp(input logic [REG_AW-1:0] wd, input logic wreg,
                          input logic [XLEN-1:0] wdata, input logic chk_wdata);
    exp_t e;
    e.wd        = wd;
    e.wreg      = wreg;
    e.wdata     = wdata;
    e.chk_wdata = chk_wdata;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expected writeback and compare with the DUT result.
  task automatic sb_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_sb: got valid_o=1 wd=%0d expected no result", tag, wd_o);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_wd"}, 64'(wd_o), 64'(e.wd));
      chk({tag, "_wreg"}, 64'(wreg_o), 64'(e.wreg));
      if (e.chk_wdata) chk({tag, "_wdata"}, wdata_o, e.wdata);
      $display("result %s: wd=%0d wreg=%0b wdata=0x%0h", tag, wd_o, wreg_o, wdata_o);
    end
  endtask

  // One aligned memory op: accept, ack_cyc BUS cycles (ack in the last), RESP.
  task automatic run_mem(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [XLEN-1:0] addr, input logic [XLEN-1:0] sdata,
                         input logic [REG_AW-1:0] wd, input int ack_cyc, input logic [XLEN-1:0] rdata,
                         input logic [XLEN-1:0] exp_wdata, input logic [XLEN-1:0] exp_bus_wdata,
                         input logic [7:0] exp_mask);
    int stalls;
    stalls = 0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, we, size, uns, addr, sdata, wd, 1'b1, 64'h0);
    bus.bus_ack   = 1'b1;                      // stray ack while IDLE
    bus.bus_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    push_exp(wd, ~we, exp_wdata, ~we);
    @(negedge clk);
    if (stall_o) stalls++;
    chk({tag, "_acc_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_acc_req"}, 64'(bus.bus_req), 64'd0);
    for (int c = 1; c <= ack_cyc; c++) begin
      @(posedge clk); #1;
      bus.bus_ack   = (c == ack_cyc);
      bus.bus_rdata = (c == ack_cyc) ? rdata : 64'hBAD1_BAD1_BAD1_BAD1;
      drive(1'b1, 1'b1, ~we, ~size, ~uns, addr ^ 64'hF0F0, ~sdata, ~wd, 1'b1, 64'h0);
      @(negedge clk);
      if (stall_o) stalls++;
      chk({tag, "_bus_req"}, 64'(bus.bus_req), 64'd1);
      chk({tag, "_bus_we"}, 64'(bus.bus_we), 64'(we));
      chk({tag, "_bus_addr"}, bus.bus_addr, {addr[XLEN-1:3], 3'b000});
      chk({tag, "_bus_mask"}, 64'(bus.bus_wmask), 64'(exp_mask));
      chk({tag, "_bus_wdata"}, bus.bus_wdata, exp_bus_wdata);
      chk({tag, "_bus_valid"}, 64'(valid_o), 64'd0);
    end
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd30, 1'b1, 64'hFFFF);
    @(negedge clk);
    if (stall_o) stalls++;
    chk({tag, "_resp_valid"}, 64'(valid_o), 64'd1);
    chk({tag, "_resp_req"}, 64'(bus.bus_req), 64'd0);
    if (valid_o) sb_check(tag);
    chk({tag, "_stall_cycles"}, 64'(stalls), 64'(ack_cyc + 1));
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 64'h0);
    bus.bus_ack = 1'b1;                        // stray ack after completion
    @(negedge clk);
    chk({tag, "_after_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_after_stall"}, 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_after_req"}, 64'(bus.bus_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 64'h0,    5'd5,  1'b1, 64'h1234,                1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 64'h0,    5'd31, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,    5'd7,  1'b1, 64'h55,                  1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 2'd3, 64'h1000, 5'd7,  1'b1, 64'h0,                   1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 2'd2, 64'h1002, 5'd4,  1'b1, 64'h0,                   1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 2'd1, 64'h1001, 5'd6,  1'b1, 64'h0,                   1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 2'd3, 64'h1004, 5'd8,  1'b1, 64'h0,                   1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 2'd2, 64'h100E, 5'd9,  1'b1, 64'h0,                   1'b1, 1'b0, 1'b1};

    // Reset with an ALU op presented: every output must stay low.
    rst = 1'b1;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd5, 1'b1, 64'h1234);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_wreg", 64'(wreg_o), 64'd0);
    chk("rst_wdata", wdata_o, 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_req", 64'(bus.bus_req), 64'd0);
    $display("reset: valid=%0b wdata=0x%0h req=%0b", valid_o, wdata_o, bus.bus_req);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-cycle cases: ALU pass-through, idle, misaligned accesses.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].v, tbl[i].en, tbl[i].we, tbl[i].size, 1'b0, tbl[i].addr, 64'hA5A5,
            tbl[i].wd, tbl[i].wreg, tbl[i].wdata);
      if (tbl[i].e_valid && !tbl[i].e_mis) push_exp(tbl[i].wd, tbl[i].wreg, tbl[i].wdata, 1'b1);
      @(negedge clk);
      chk($sformatf("t%0d_valid", i), 64'(valid_o), 64'(tbl[i].e_valid));
      chk($sformatf("t%0d_wreg", i), 64'(wreg_o), 64'(tbl[i].e_wreg));
      chk($sformatf("t%0d_mis", i), 64'(misalign_o), 64'(tbl[i].e_mis));
      chk($sformatf("t%0d_stall", i), 64'(stall_o), 64'd0);
      chk($sformatf("t%0d_req", i), 64'(bus.bus_req), 64'd0);
      if (valid_o && !misalign_o) sb_check($sformatf("t%0d", i));
      else if (tbl[i].e_valid && !tbl[i].e_mis && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      $display("vec %0d: valid=%0b wreg=%0b mis=%0b stall=%0b", i, valid_o, wreg_o, misalign_o, stall_o);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 64'h0);
    @(negedge clk);
    chk("mis_after_req", 64'(bus.bus_req), 64'd0);
    chk("mis_after_stall", 64'(stall_o), 64'd0);

    // Multi-cycle memory operations.
    run_mem("lb",  1'b0, 2'd0, 1'b0, 64'h1003, 64'h0,         5'd7,  3, 64'h0000_0000_8000_0000,
            64'hFFFF_FFFF_FFFF_FF80, 64'h0, 8'h08);
    run_mem("sh",  1'b1, 2'd1, 1'b0, 64'h2006, 64'hBEEF,      5'd3,  1, 64'h1111_2222_3333_4444,
            64'h0, 64'hBEEF_0000_0000_0000, 8'hC0);
    run_mem("lhu", 1'b0, 2'd1, 1'b1, 64'h0012, 64'h0,         5'd10, 1, 64'h0000_0000_ABCD_0000,
            64'h0000_0000_0000_ABCD, 64'h0, 8'h0C);
    run_mem("lw",  1'b0, 2'd2, 1'b0, 64'h1004, 64'h0,         5'd11, 2, 64'h8765_4321_0000_0000,
            64'hFFFF_FFFF_8765_4321, 64'h0, 8'hF0);
    run_mem("ld",  1'b0, 2'd3, 1'b0, 64'h2008, 64'h0,         5'd12, 1, 64'h0123_4567_89AB_CDEF,
            64'h0123_4567_89AB_CDEF, 64'h0, 8'hFF);
    run_mem("lbu", 1'b0, 2'd0, 1'b1, 64'h3005, 64'h0,         5'd13, 2, 64'h0000_9A00_0000_0000,
            64'h0000_0000_0000_009A, 64'h0, 8'h20);
    run_mem("sw",  1'b1, 2'd2, 1'b0, 64'h400C, 64'h1234_5678, 5'd14, 1, 64'h0,
            64'h0, 64'h1234_5678_0000_0000, 8'hF0);

    // Reset while a bus beat is outstanding, ack arrives afterwards.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h3000, 64'h0, 5'd12, 1'b1, 64'h0);
    @(negedge clk);
    chk("rb_acc_stall", 64'(stall_o), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_bus_req", 64'(bus.bus_req), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd2, 1'b1, 64'h7);
    @(negedge clk);
    chk("rb_rst_req", 64'(bus.bus_req), 64'd0);
    chk("rb_rst_valid", 64'(valid_o), 64'd0);
    chk("rb_rst_wdata", wdata_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 64'h0);
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = 64'hFEED_FACE_FEED_FACE;
    @(negedge clk);
    chk("rb_late_ack_req", 64'(bus.bus_req), 64'd0);
    chk("rb_late_ack_valid", 64'(valid_o), 64'd0);
    @(posedge clk); #1;
    bus.bus_ack = 1'b0;
    @(negedge clk);
    chk("rb_next_valid", 64'(valid_o), 64'd0);
    chk("rb_next_stall", 64'(stall_o), 64'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd9, 1'b1, 64'hCAFE);
    push_exp(5'd9, 1'b1, 64'hCAFE, 1'b1);
    @(negedge clk);
    chk("rb_alu_valid", 64'(valid_o), 64'd1);
    chk("rb_alu_stall", 64'(stall_o), 64'd0);
    if (valid_o) sb_check("rb_alu");
    else if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);

    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 64'h0);
    chk("sb_leftover", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
